mcp3008_responder: RTL and testbench

- Behavioural SPI responder for the 10-bit, 8-channel MCP3008 ADC. It answers the ADC-scan initiator in the motor controller (CS, DIN and AD_CLK out; DOUT in).
- Runs on the system clock and oversamples the SPI pins. The channel values it returns come from a flat input bus.
- Used as the on-FPGA ADC stand-in for hardware-less bring-up, and as the loopback target in the motor-control testbench.

---
 rtl/mcp3008_responder_if.sv | 12 +
 rtl/mcp3008_responder.sv | 164 ++++++++++++++++
 tb/tb_mcp3008_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcp3008_responder_if.sv
// SPI pin bundle between the MCP3008 scan initiator (master) and the responder (slave).
// There is no valid/ready on this link: the initiator owns cs_n/sclk/din, and the responder drives dout only while dout_oe is high.
interface mcp3008_responder_if;
    logic sclk;
    logic cs_n;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output sclk, output cs_n, output din, input dout, input dout_oe);
    modport slave  (input sclk, input cs_n, input din, output dout, output dout_oe);
endinterface

// File: rtl/mcp3008_responder.sv
// Behavioural MCP3008 SPI responder: oversamples the SPI pins on clk and returns channel values from ch_data.
// conv_valid is a single-clk pulse with no backpressure; conv_* hold until the next capture.
module mcp3008_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 10,
    parameter int NUM_CH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mcp3008_responder_if.slave       spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     conv_valid,
    output logic [2:0]               conv_ch,
    output logic                     conv_sgl,
    output logic [DATA_W-1:0]        conv_result,
    output logic                     busy,
    output logic [2:0]               state_dbg
);
    typedef enum logic [2:0] {IDLE, WAIT_START, CMD, SAMPLE, OUT, DONE} state_t;

    // Index DATA_W marks the null bit; the all-ones value marks "past B0".
    localparam int IDX_W = $clog2(DATA_W + 2);

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
    logic                   sclk_prev;
    logic                   cs_s, sclk_s, din_s, sclk_rise, sclk_fall;

    state_t              state_q, state_d;
    logic [1:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          cmd_q, cmd_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic                dout_q, dout_d, oe_q, oe_d;
    logic                valid_d, sgl_d;
    logic [2:0]          ch_d;
    logic [DATA_W-1:0]   res_d;

    logic [2:0]          sel_w;
    logic [DATA_W-1:0]   pos_val, neg_val, conv_value;
    logic [DATA_W:0]     diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            din_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], spi.din};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // Channel select is complete on the D0 edge: the last bit arrives on din_s.
    // In differential mode IN+ is the selected channel and IN- its pair partner.
    always_comb begin
        sel_w      = {cmd_q[1:0], din_s};
        pos_val    = ch_data[int'(sel_w) * DATA_W +: DATA_W];
        neg_val    = ch_data[int'(sel_w ^ 3'd1) * DATA_W +: DATA_W];
        diff       = {1'b0, pos_val} - {1'b0, neg_val};
        conv_value = cmd_q[2] ? pos_val : (diff[DATA_W] ? '0 : diff[DATA_W-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        out_idx_d = out_idx_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        valid_d   = 1'b0;
        ch_d      = conv_ch;
        sgl_d     = conv_sgl;
        res_d     = conv_result;
        if (cs_s) begin
            state_d = IDLE;
            dout_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_START;
                WAIT_START: begin
                    if (sclk_rise && din_s) begin
                        state_d   = CMD;
                        bit_cnt_d = 2'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d     = {cmd_q[1:0], din_s};
                        bit_cnt_d = bit_cnt_q + 2'd1;
                        if (bit_cnt_q == 2'd3) begin
                            valid_d = 1'b1;
                            sgl_d   = cmd_q[2];
                            ch_d    = sel_w;
                            res_d   = conv_value;
                            state_d = SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (sclk_rise) begin
                        state_d   = OUT;
                        out_idx_d = IDX_W'(DATA_W);
                    end
                end
                OUT: begin
                    if (sclk_fall) begin
                        out_idx_d = out_idx_q - 1'b1;
                        if (out_idx_q == IDX_W'(DATA_W)) begin
                            oe_d   = 1'b1;
                            dout_d = 1'b0;
                        end else if (out_idx_q == '1) begin
                            dout_d  = 1'b0;
                            state_d = DONE;
                        end else begin
                            dout_d = conv_result[out_idx_q];
                        end
                    end
                end
                DONE:    dout_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            out_idx_q   <= '0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            conv_valid  <= 1'b0;
            conv_ch     <= '0;
            conv_sgl    <= 1'b0;
            conv_result <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            out_idx_q   <= out_idx_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            conv_valid  <= valid_d;
            conv_ch     <= ch_d;
            conv_sgl    <= sgl_d;
            conv_result <= res_d;
        end
    end

    assign spi.dout    = dout_q;
    assign spi.dout_oe = oe_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed-plus-random bench for mcp3008_responder: an SPI initiator model drives frames and an arithmetic channel model predicts results.
module tb_mcp3008_responder;
    localparam int SYNC_STAGES = 2;
    localparam int DATA_W      = 10;
    localparam int NUM_CH      = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     conv_valid, conv_sgl, busy;
    logic [2:0]               conv_ch, state_dbg;
    logic [DATA_W-1:0]        conv_result;

    mcp3008_responder_if spi_if();

    mcp3008_responder #(.SYNC_STAGES(SYNC_STAGES), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi_if), .ch_data(ch_data),
        .conv_valid(conv_valid), .conv_ch(conv_ch), .conv_sgl(conv_sgl),
        .conv_result(conv_result), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int tests = 0;
    int fails = 0;
    int cv_count = 0;
    int ch_model[NUM_CH];
    logic [DATA_W-1:0] exp_q[$];
    bit swap_armed = 1'b0;
    bit swap_pending = 1'b0;
    int swap_ch = 0;
    int swap_val = 0;

    always @(negedge clk) if (conv_valid === 1'b1) cv_count++;

    // Scoreboard check
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: single-ended returns the channel, differential subtracts the pair partner and clamps at zero.
    function automatic int model(input bit sgl, input int sel);
        int base, plus, minus, r;
        if (sgl) return ch_model[sel];
        base  = (sel / 2) * 2;
        plus  = base + (sel % 2);
        minus = base + 1 - (sel % 2);
        r     = ch_model[plus] - ch_model[minus];
        return (r < 0) ? 0 : r;
    endfunction

    task automatic set_ch(input int n, input int v);
        logic [31:0] vv;
        vv = v;
        ch_model[n] = v;
        ch_data[n*DATA_W +: DATA_W] = vv[DATA_W-1:0];
    endtask

    // Driver tasks
    task automatic rise_half(input logic d, input int h, output logic q);
        spi_if.din = d;
        repeat (h) @(negedge clk);
        spi_if.sclk = 1'b1;
        q = spi_if.dout;
    endtask

    task automatic fall_half(input int h);
        for (int k = 0; k < h; k++) begin
            @(negedge clk);
            if (swap_pending) begin
                set_ch(swap_ch, swap_val);
                swap_pending = 1'b0;
            end else if (swap_armed && conv_valid === 1'b1) begin
                swap_pending = 1'b1;
                swap_armed   = 1'b0;
            end
        end
        spi_if.sclk = 1'b0;
    endtask

    task automatic clock_bit(input logic d, input int h, output logic q);
        rise_half(d, h, q);
        fall_half(h);
    endtask

    // Rise 0 is the start bit; null is read at rise 6 and B0 at rise 16.
    task automatic run_frame(input int lead, input bit sgl, input int sel, input int h,
                             input int stop_rise, output logic [DATA_W-1:0] bits, output logic null_bit);
        logic q;
        logic [31:0] s;
        s = sel;
        bits = '0;
        null_bit = 1'b1;
        spi_if.cs_n = 1'b0;
        for (int i = 0; i < lead; i++) clock_bit(1'b0, h, q);
        clock_bit(1'b1, h, q);
        clock_bit(sgl, h, q);
        for (int j = 2; j >= 0; j--) clock_bit(s[j], h, q);
        for (int r = 5; r <= stop_rise; r++) begin
            clock_bit(1'b0, h, q);
            if (r == 6) null_bit = q;
            else if (r >= 7) bits[16-r] = q;
        end
    endtask

    task automatic end_frame();
        spi_if.cs_n = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge clk);
    endtask

    task automatic full_frame(input bit sgl, input int sel, input int h, input int lead);
        logic [DATA_W-1:0] bits, e;
        logic nb, q;
        int c0;
        exp_q.push_back(DATA_W'(model(sgl, sel)));
        c0 = cv_count;
        run_frame(lead, sgl, sel, h, 16, bits, nb);
        repeat (SYNC_STAGES + 2) @(negedge clk);
        e = exp_q.pop_front();
        chk("conv_valid_pulses", cv_count - c0, 1);
        chk("conv_ch", conv_ch, sel);
        chk("conv_sgl", conv_sgl, sgl);
        chk("conv_result", conv_result, e);
        chk("null_bit", nb, 0);
        chk("dout_bits", bits, e);
        chk("done_dout", spi_if.dout, 0);
        clock_bit(1'b0, h, q);
        repeat (SYNC_STAGES + 2) @(negedge clk);
        chk("done_extra_edge_dout", spi_if.dout, 0);
        chk("done_dout_oe", spi_if.dout_oe, 1);
        chk("done_busy", busy, 1);
        end_frame();
        chk("idle_dout_oe", spi_if.dout_oe, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"}, spi_if.dout, 0);
        chk({tag, "_dout_oe"}, spi_if.dout_oe, 0);
        chk({tag, "_conv_valid"}, conv_valid, 0);
        chk({tag, "_conv_ch"}, conv_ch, 0);
        chk({tag, "_conv_sgl"}, conv_sgl, 0);
        chk({tag, "_conv_result"}, conv_result, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] bits, e;
        logic nb, q;
        int c0, h, sel;

        rst_n = 1'b0;
        spi_if.cs_n = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.din  = 1'b0;
        ch_data = '0;
        for (int n = 0; n < NUM_CH; n++) set_ch(n, $urandom_range(0, 1023));
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single-ended read of channel 5 with two leading zeros
        set_ch(5, 'h2A5);
        full_frame(1'b1, 5, SYNC_STAGES + 2, 2);

        // Differential pair 2/3: negative clamps, positive subtracts
        set_ch(2, 100);
        set_ch(3, 300);
        full_frame(1'b0, 2, $urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 4), 0);
        full_frame(1'b0, 3, $urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 4), 1);

        // Abort after B6 has shifted out
        sel = $urandom_range(0, 7);
        h = $urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 4);
        e = DATA_W'(model(1'b1, sel));
        run_frame(1, 1'b1, sel, h, 10, bits, nb);
        chk("abort_partial_bits", bits[9:6], e[9:6]);
        spi_if.cs_n = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        chk("abort_dout_oe", spi_if.dout_oe, 0);
        chk("abort_busy", busy, 0);
        repeat (SYNC_STAGES + 2) @(negedge clk);
        set_ch(0, 'h3FF);
        full_frame(1'b1, 0, h, 0);

        // Reset pulse while in CMD; the broken frame must not produce a conversion
        c0 = cv_count;
        h = SYNC_STAGES + 3;
        spi_if.cs_n = 1'b0;
        clock_bit(1'b1, h, q);
        clock_bit(1'b1, h, q);
        clock_bit(1'b1, h, q);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        chk("midreset_no_conv", cv_count - c0, 0);
        full_frame(1'b1, $urandom_range(0, 7), h, 2);

        // ch_data changes one clk after capture; shifted bits keep the captured value
        set_ch(7, 'h155);
        swap_ch = 7;
        swap_val = 'h0AA;
        swap_armed = 1'b1;
        full_frame(1'b1, 7, SYNC_STAGES + 2, 1);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < NUM_CH; n++) set_ch(n, $urandom_range(0, 1023));
            full_frame(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       $urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 4), $urandom_range(0, 3));
        end

        // Scan loop at the minimum sclk half-period
        for (int n = 0; n < NUM_CH; n++) set_ch(n, n * 128 + $urandom_range(0, 127));
        c0 = cv_count;
        for (int s = 0; s < NUM_CH; s++) full_frame(1'b1, s, SYNC_STAGES + 2, 0);
        chk("scan_conv_valid_count", cv_count - c0, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
